// File: rtl/axil_reg_pkg.sv
// -----------------------------------------------------------------------------
// axil_reg_pkg
// Shared definitions for the AXI4-Lite register slave:
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   wr_state_t              : write-channel FSM states
//   rd_state_t              : read-channel FSM states
//   apply_wstrb()           : byte-strobed merge of new data into an old word
// -----------------------------------------------------------------------------
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_W    = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Byte b of the result comes from data where strb[b]=1, else from old.
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = data[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// -----------------------------------------------------------------------------
// axil_reg_bank
// NUM_REGS x 32-bit register array with byte-strobed write and a one-cycle
// per-register write pulse.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (clears all registers)
//   i_we         : commit a write on this edge
//   i_idx        : register index to write
//   i_data       : write data
//   i_strb       : byte strobes (bit b enables byte b)
//   o_reg_q      : flattened contents, register k at [32k+31:32k]
//   o_reg_wr     : one-hot pulse, high the cycle after a committing edge
// -----------------------------------------------------------------------------
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic [31:0]              i_data,
    input  logic [3:0]               i_strb,
    output logic [NUM_REGS*32-1:0]   o_reg_q,
    output logic [NUM_REGS-1:0]      o_reg_wr
);

    logic [31:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_wr <= '0;
        end else begin
            r_wr <= '0;
            if (i_we) begin
                r_regs[i_idx] <= apply_wstrb(r_regs[i_idx], i_data, i_strb);
                r_wr[i_idx]   <= 1'b1;
            end
        end
    end

    always_comb begin
        o_reg_q = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            o_reg_q[k*32 +: 32] = r_regs[k];
        end
    end

    assign o_reg_wr = r_wr;

endmodule

// File: rtl/axil_reg_slave.sv
// -----------------------------------------------------------------------------
// axil_reg_slave
// AXI4-Lite slave register file (S00_AXI of final_v1_0). AW and W are accepted
// independently in either order; one write and one read may be in flight.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET : clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response channels
//   S_AXI_AR* / S_AXI_R*            : read address and data channels
//   reg_q  : flattened register contents, register k at [32k+31:32k]
//   reg_wr : one-cycle per-register pulse on the cycle a write commits
// Build option:
//   AXIL_REG_SLAVE_SLVERR_EN : when defined, addresses with any nonzero bit
//   above the index field get SLVERR (no write, RDATA=0); otherwise upper
//   address bits are ignored and addresses alias modulo NUM_REGS.
// -----------------------------------------------------------------------------
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_q,
    output logic [NUM_REGS-1:0]             reg_wr
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int AW    = C_S_AXI_ADDR_WIDTH;

    // ---------------------------------------------------------------- write
    wr_state_t         r_wstate;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [AW-1:0]     r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_commit;
    logic [AW-1:0]     w_wr_addr;
    logic [31:0]       w_wr_data;
    logic [3:0]        w_wr_strb;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_wr_oor;
    logic              w_wr_en;
    logic [1:0]        w_wr_resp;

    assign w_aw_hs = S_AXI_AWVALID & r_awready;
    assign w_w_hs  = S_AXI_WVALID  & r_wready;

    // The commit happens on the edge of the later handshake; whichever half
    // arrived earlier is taken from its latch, the other straight off the bus.
    always_comb begin
        w_commit = 1'b0;
        case (r_wstate)
            W_IDLE:  w_commit = w_aw_hs & w_w_hs;
            W_AW:    w_commit = w_w_hs;
            W_W:     w_commit = w_aw_hs;
            default: w_commit = 1'b0;
        endcase
    end

    assign w_wr_addr = (r_wstate == W_AW) ? r_awaddr : S_AXI_AWADDR;
    assign w_wr_data = (r_wstate == W_W)  ? r_wdata  : S_AXI_WDATA;
    assign w_wr_strb = (r_wstate == W_W)  ? r_wstrb  : S_AXI_WSTRB;
    assign w_wr_idx  = w_wr_addr[IDX_W+1:2];

    // ---------------------------------------------------------------- read
    rd_state_t         r_rstate;
    logic              r_arready;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic [31:0]       r_rdata;

    logic              w_ar_hs;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_oor;
    logic [31:0]       w_rd_word;

    assign w_ar_hs   = S_AXI_ARVALID & r_arready;
    assign w_rd_idx  = S_AXI_ARADDR[IDX_W+1:2];
    assign w_rd_word = reg_q[w_rd_idx*32 +: 32];

`ifdef AXIL_REG_SLAVE_SLVERR_EN
    assign w_wr_oor = |(w_wr_addr >> (IDX_W + 2));
    assign w_rd_oor = |(S_AXI_ARADDR >> (IDX_W + 2));
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    assign w_wr_en   = w_commit & ~w_wr_oor;
    assign w_wr_resp = w_wr_oor ? RESP_SLVERR : RESP_OKAY;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_wr_addr, S_AXI_ARADDR};

    // Readies are registered and held low in reset, so they rise on the first
    // edge after reset release and never depend combinationally on a VALID.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_resp;
                    end else if (w_aw_hs) begin
                        r_wstate  <= W_AW;
                        r_awaddr  <= S_AXI_AWADDR;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= W_W;
                        r_wdata   <= S_AXI_WDATA;
                        r_wstrb   <= S_AXI_WSTRB;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_AW: begin
                    if (w_w_hs) begin
                        r_wstate <= W_RESP;
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wr_resp;
                    end
                end
                W_W: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_resp;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Read data is captured from the pre-edge register contents, so a read
    // racing a write commit to the same register returns the old value.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_oor ? '0 : w_rd_word;
                        r_rresp   <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .i_clk    (S_AXI_ACLK),
        .i_rst    (S_AXI_ARESET),
        .i_we     (w_wr_en),
        .i_idx    (w_wr_idx),
        .i_data   (w_wr_data),
        .i_strb   (w_wr_strb),
        .o_reg_q  (reg_q),
        .o_reg_wr (reg_wr)
    );

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite slave register file that terminates the S00_AXI port of the final_v1_0 IP: the master VIP in the block-design bench drives it directly. It holds NUM_REGS 32-bit read/write registers, accepts AW and W independently in either order, honours WSTRB, and exposes register contents and per-register write strobes to user logic. One write and one read may be in flight at the same time, with at most one outstanding transaction on each channel.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width. Bits [1:0] are ignored.
- NUM_REGS, 4: register count. Must be a power of two and at most 2^(C_S_AXI_ADDR_WIDTH-2).
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_W/3/1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_W/3/1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- reg_q  out  NUM_REGS*32  current register contents. Register k occupies bits [32k+31:32k].
- reg_wr  out  NUM_REGS  one-cycle pulse on the cycle a register's write commits.

## Operation
Write FSM has four states:
- W_IDLE: AWREADY=1 and WREADY=1.
- W_AW: address latched, AWREADY=0, WREADY=1.
- W_W: data and strobe latched, WREADY=0, AWREADY=1.
- W_RESP: BVALID=1, AWREADY=0, WREADY=0.

Write transitions:
- Both handshakes in the same cycle from W_IDLE: go to W_RESP.
- One handshake only: go to W_AW or W_W as appropriate. The missing handshake then moves to W_RESP.
- On entry to W_RESP, the addressed register updates byte-wise: byte b is written only where WSTRB[b]=1. reg_wr[idx] pulses for that same cycle.
- BRESP=OKAY (2'b00).
- W_RESP returns to W_IDLE on BVALID & BREADY.
- A write with WSTRB=0 still completes and still pulses reg_wr, but data is unchanged.
- AWPROT and ARPROT are ignored.

Read FSM has two states:
- R_IDLE: ARREADY=1.
- R_DATA: RVALID=1, ARREADY=0.
- On an AR handshake, RDATA captures reg[ARADDR[..2]] and the FSM goes to R_DATA.
- RDATA and RRESP stay stable until RVALID & RREADY, then the FSM returns to R_IDLE.

Register index is addr[log2(NUM_REGS)+1:2]. Higher address bits are handled by SLVERR_EN (see Configuration).

If a write commit and an AR handshake to the same register land on the same edge, RDATA returns the pre-write value.

## Timing
Reset values:
- All registers 0.
- AWREADY=WREADY=ARREADY=0 while S_AXI_ARESET is high. All three go to 1 on the first clock edge after deassertion.
- BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0, reg_wr=0.

Latency:
- Write: the later of the AW/W handshakes happens at edge N. BVALID and the register update appear after edge N+1.
- Read: AR handshake at edge N. RVALID and RDATA are valid after edge N+1.
- No combinational path from any VALID to any READY.
- Back-to-back throughput is one write per 2 cycles and one read per 2 cycles when BREADY/RREADY are held high.

Reset asserted mid-transaction:
- Both FSMs go to IDLE immediately. Any latched AW or W is discarded and no commit occurs.
- BVALID and RVALID drop asynchronously.

## Configuration
AXIL_REG_SLAVE_SLVERR_EN controls out-of-range addresses, i.e. any nonzero address bit above the index field.
- Defined:
  - A write to an out-of-range address returns BRESP=SLVERR (2'b10) and modifies no register. No reg_wr pulse occurs.
  - A read from an out-of-range address returns RRESP=SLVERR with RDATA=0.
- Undefined: upper address bits are ignored, addresses alias modulo NUM_REGS, and responses are always OKAY.

## Structure
- Shared package axil_reg_pkg holds:
  - the AXI response constants RESP_OKAY and RESP_SLVERR;
  - the wr_state_t enum (W_IDLE, W_AW, W_W, W_RESP);
  - the rd_state_t enum (R_IDLE, R_DATA);
  - the function apply_wstrb(old, data, strb).
- The register array and its byte-strobed update are naturally split into the sub-module axil_reg_bank: inputs are write enable, index, data and strobe; outputs are reg_q and reg_wr. This top level keeps the AXI handshake FSMs.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back the same addresses. Expect RDATA 0x1, 0x2, 0x3, 0x4 with all BRESP and RRESP = OKAY, and reg_q = 0x00000004_00000003_00000002_00000001.
- Drive AWVALID to 0x8 three cycles before WVALID with data 0xDEADBEEF. Expect WREADY to stay 1 while waiting, then BVALID one cycle after the W handshake, reg_wr = 4'b0100, and reg2 = 0xDEADBEEF.
- Start with reg0 = 0x00000001. Write 0xAABBCCDD to 0x0 with WSTRB = 4'b0010. Expect reg0 = 0x0000CC01.
- Hold BREADY low for 5 cycles after a write. Expect BVALID to stay 1, AWREADY = WREADY = 0, and a second AW not accepted until the B handshake.
- Write 0x55 to 0x10, then read 0x10. With the macro defined: expect BRESP = RRESP = 2'b10, RDATA = 0, and registers unchanged. Without the macro: expect reg0 = 0x55 and a read of 0x10 returning 0x55.
- Assert reset for 2 cycles while the FSM is in W_AW, then deassert and read 0x0. Expect BVALID never asserted, all of reg_q = 0, and the read returning 0x0 with OKAY.
